// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: remembers the last served master, lock forces m1.
module rr_pick2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic lock,
  input  logic upd,
  input  logic upd_id,
  output logic win
);

  logic last_q;
  logic last_d;

  always_comb begin
    last_d = last_q;
    if (upd) begin
      last_d = upd_id;
    end else begin
      last_d = last_q;
    end
  end

  // Resetting "last served" to m1 makes m0 the favoured master after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    win = 1'b0;
    case ({req1, req0})
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = lock ? 1'b1 : ~last_q;
      default: win = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-beat memory port between the CPU (m0) and the loader (m1)
// with round-robin arbitration, fixed wait states and an m1 priority lock.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_we,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_we,
  input  logic              m1_lock,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_id
);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rd0_q, rd0_d;
  logic [DATA_W-1:0]     rd1_q, rd1_d;
  logic                  win;
  logic                  last_acc;

  rr_pick2 u_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (m0_req),
    .req1   (m1_req),
    .lock   (m1_lock),
    .upd    (state_q == RESP),
    .upd_id (gnt_q),
    .win    (win)
  );

  assign last_acc = (cnt_q == WAIT_CNT_W'(WAIT_CYCLES));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ACCESS;
          cnt_d   = {WAIT_CNT_W{1'b0}};
          gnt_d   = win;
          if (win) begin
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
            we_d    = m1_we;
          end else begin
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            we_d    = m0_we;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (last_acc) begin
          state_d = RESP;
          cnt_d   = {WAIT_CNT_W{1'b0}};
          // Only reads update the returned data; writes keep the old value.
          if (!we_q) begin
            if (gnt_q) begin
              rd1_d = mem_rdata;
            end else begin
              rd0_d = mem_rdata;
            end
          end else begin
            rd0_d = rd0_q;
          end
        end else begin
          cnt_d = cnt_q + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {WAIT_CNT_W{1'b0}};
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      rd0_q   <= {DATA_W{1'b0}};
      rd1_q   <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign gnt_id    = gnt_q;
  assign m0_ack    = (state_q == RESP) & ~gnt_q;
  assign m1_ack    = (state_q == RESP) & gnt_q;
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;

endmodule
